dm_sba_ext: RTL
===============

# dm_sba_ext

Second-generation system bus access engine for the debug module. It executes single SBA read/write transactions on a parametrised request/grant/valid bus master port. It latches the access attributes at launch, checks size and alignment, aligns read data to bit 0, and replicates write data across byte lanes. It reports bus errors and a timeout, flags busy violations, and performs auto-increment. It sits between the DM CSR block (sbcs/sbaddress/sbdata) and the system interconnect.

## Interface
- BusWidth, 64: data bus width in bits; legal values 32 or 64.
- AddrWidth, 64: address width in bits; range 32..64.
- TimeoutCycles, 1024: cycles a transaction may stay outstanding before abort; 0 disables the timeout.

- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- dmactive_i  in  1  low = synchronous clear, same effect as rst_i
- master_req_o / master_we_o  out  1  bus request / write enable
- master_add_o  out  AddrWidth  bus address, word-aligned (low log2(BusWidth/8) bits zero)
- master_wdata_o  out  BusWidth  write data, replicated lanes
- master_be_o  out  BusWidth/8  byte enables
- master_gnt_i / master_r_valid_i / master_r_err_i  in  1  grant / response valid / response error
- master_r_rdata_i  in  BusWidth  response data
- sbaddress_i  in  AddrWidth  current sbaddress; sbaddress_write_valid_i  in  1  sbaddress written
- sbdata_i  in  BusWidth  write data; sbdata_write_valid_i / sbdata_read_valid_i  in  1  sbdata0 written / read
- sbreadonaddr_i, sbreadondata_i, sbautoincrement_i  in  1  sbcs controls
- sbaccess_i  in  3  log2 access size in bytes
- sbaddress_o  out  AddrWidth  incremented address; sbaddress_valid_o  out  1  load strobe
- sbdata_o  out  BusWidth  read data, right-aligned and zero-extended; sbdata_valid_o  out  1  strobe
- sbbusy_o  out  1  engine not Idle
- sbbusyerror_o  out  1  pulse: access requested while busy
- sberror_valid_o  out  1  pulse; sberror_o  out  3  error code (1 timeout, 2 bus error, 3 misaligned, 4 unsupported size)

## Operation
- States: Idle, Req, Wait.
- Idle launch triggers: write = sbdata_write_valid_i; read = (sbaddress_write_valid_i & sbreadonaddr_i) | (sbdata_read_valid_i & sbreadondata_i). When write and read triggers coincide, write wins and the read is dropped.
- At launch the engine latches address, size, we, and wdata. Outputs are driven from the latched copies only.
- Size check: sbaccess_i > log2(BusWidth/8) → error 4, no bus activity, stay Idle.
- Alignment check: address not aligned to 2^sbaccess → error 3, no bus activity, stay Idle. The size check takes precedence over the alignment check.
- Req: master_req_o=1 until master_gnt_i; on the grant cycle → Wait.
- Wait: on master_r_valid_i → Idle.
  - err=0, read: register sbdata_o = (rdata >> 8*offset) masked to the access size; pulse sbdata_valid_o.
  - err=1: pulse sberror_valid_o with code 2. No sbdata_valid_o, no auto-increment.
  - err=0 and sbautoincrement_i: sbaddress_o = latched addr + 2^size (mod 2^AddrWidth); pulse sbaddress_valid_o.
- Write data: the low 2^size bytes of sbdata_i are replicated into every lane.
- Byte enables: master_be_o has 2^size bits set starting at offset = addr mod (BusWidth/8).
- Any trigger while not Idle: sbbusyerror_o pulses and the request is ignored.
- Timeout: the counter runs in Req and Wait. When it reaches TimeoutCycles → Idle, error 1, master_req_o drops. A late master_r_valid_i while Idle is discarded.

## Timing
- On reset or dmactive_i low, all outputs go to 0 at the next edge, state → Idle, counter cleared. This includes any abort mid-transaction; the bus is released without waiting for a response.
- Launch in cycle N → master_req_o=1 in N+1.
- Grant in cycle G → Wait from G+1. master_gnt_i and master_r_valid_i in the same cycle are not legal; the response is taken from G+1 onward.
- r_valid in cycle R → sbdata_valid_o, sbaddress_valid_o, and sberror_valid_o pulse in R+1. In R+1 the state is Idle, so a new launch is possible in R+1.
- Size and alignment errors pulse one cycle after the trigger.
- sbbusyerror_o pulses one cycle after the offending trigger.
- All pulses are exactly 1 cycle wide.
- Minimum read latency with gnt in N+1 and r_valid in N+2: sbdata_valid_o in N+3.

## Test plan
- BusWidth=64, 32-bit read at 0x1004, rdata 0xAABBCCDD_11223344, autoincrement=1 → master_add_o=0x1000, sbdata_o=0xAABBCCDD, sbaddress_o=0x1008.
- BusWidth=32, byte write of 0x5A at 0x2003 → be=4'b1000, wdata=0x5A5A5A5A; then a halfword write at 0x2001 → error 3, master_req_o never asserted.
- sbaccess=3 with BusWidth=32 → error 4. master_r_err_i=1 on a read → error 2, no sbdata_valid_o, address unchanged.
- TimeoutCycles=8, gnt withheld → req high for 8 cycles, then error 1. A late r_valid is ignored and no sbdata_valid_o occurs.
- Write trigger while in Wait → sbbusyerror_o pulse and a single bus transaction only. Simultaneous write and readonaddr triggers in Idle → only the write is issued.
- rst_i asserted in Req → master_req_o=0 next cycle, sbbusy_o=0. The next read completes normally.

Source files
------------

// File: rtl/dm_sba_ext.sv
// rtl/dm_sba_ext.sv - debug module system bus access engine
// Single-beat SBA master with size/alignment checks, lane steering, auto-increment and timeout.
module dm_sba_ext #(
  parameter int unsigned BusWidth      = 64,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  output logic                  master_req_o,
  output logic                  master_we_o,
  output logic [AddrWidth-1:0]  master_add_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,
  input  logic [AddrWidth-1:0]  sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_write_valid_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbreadondata_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  output logic [AddrWidth-1:0]  sbaddress_o,
  output logic                  sbaddress_valid_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sbbusyerror_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o
);
  localparam int NumBytes = BusWidth / 8;
  localparam int OffW     = $clog2(NumBytes);
  localparam int CntW     = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  typedef enum logic [1:0] {Idle, Req, Wait} state_e;

  state_e               state_q, state_d;
  logic                 clear;
  logic                 trig_wr, trig_rd, trig_any;
  logic                 size_bad, align_bad, launch, timeout, rsp;
  logic [OffW-1:0]      align_mask, size_mask_q;
  logic [AddrWidth-1:0] addr_q;
  logic [2:0]           size_q;
  logic                 we_q;
  logic [BusWidth-1:0]  wdata_q, wdata_d, rdata_aligned;
  logic [NumBytes-1:0]  be_q, be_d;
  logic [CntW-1:0]      cnt_q;

  // Low-address-bit mask covering one access of 2^size bytes.
  function automatic logic [OffW-1:0] size_mask(input logic [2:0] size);
    logic [OffW-1:0] m;
    for (int i = 0; i < OffW; i++) m[i] = (i < int'(size));
    return m;
  endfunction

  assign clear      = rst_i | ~dmactive_i;
  assign trig_wr    = sbdata_write_valid_i;
  assign trig_rd    = (sbaddress_write_valid_i & sbreadonaddr_i) | (sbdata_read_valid_i & sbreadondata_i);
  assign trig_any   = trig_wr | trig_rd;
  assign align_mask = size_mask(sbaccess_i);
  assign size_bad   = sbaccess_i > 3'(OffW);
  assign align_bad  = |(sbaddress_i[OffW-1:0] & align_mask);
  assign launch     = (state_q == Idle) & trig_any & ~size_bad & ~align_bad;
  assign size_mask_q = size_mask(size_q);

  always_comb begin
    wdata_d = '0;
    be_d    = '0;
    for (int i = 0; i < NumBytes; i++) begin
      wdata_d[8*i +: 8] = sbdata_i[{OffW'(i) & align_mask, 3'b000} +: 8];
      be_d[i]           = ((OffW'(i) & ~align_mask) == sbaddress_i[OffW-1:0]);
    end
  end

  always_comb begin
    rdata_aligned = '0;
    for (int j = 0; j < NumBytes; j++) begin
      if ((OffW'(j) & ~size_mask_q) == '0)
        rdata_aligned[8*j +: 8] = master_r_rdata_i[{addr_q[OffW-1:0] + OffW'(j), 3'b000} +: 8];
    end
  end

  // Timeout outranks a grant or response arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    timeout = (TimeoutCycles != 0) && (state_q != Idle) && (cnt_q == CntLast);
    rsp     = 1'b0;
    unique case (state_q)
      Idle: if (launch) state_d = Req;
      Req: begin
        if (timeout) state_d = Idle;
        else if (master_gnt_i) state_d = Wait;
      end
      Wait: begin
        if (timeout) state_d = Idle;
        else if (master_r_valid_i) begin
          state_d = Idle;
          rsp     = 1'b1;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      state_q           <= Idle;
      cnt_q             <= '0;
      addr_q            <= '0;
      size_q            <= '0;
      we_q              <= 1'b0;
      wdata_q           <= '0;
      be_q              <= '0;
      sbaddress_o       <= '0;
      sbaddress_valid_o <= 1'b0;
      sbdata_o          <= '0;
      sbdata_valid_o    <= 1'b0;
      sbbusyerror_o     <= 1'b0;
      sberror_valid_o   <= 1'b0;
      sberror_o         <= '0;
    end else begin
      state_q           <= state_d;
      sbaddress_valid_o <= 1'b0;
      sbdata_valid_o    <= 1'b0;
      sbbusyerror_o     <= 1'b0;
      sberror_valid_o   <= 1'b0;
      cnt_q <= (state_q == Idle || state_d == Idle) ? '0 : cnt_q + CntW'(1);
      if (launch) begin
        addr_q  <= sbaddress_i;
        size_q  <= sbaccess_i;
        we_q    <= trig_wr;
        wdata_q <= wdata_d;
        be_q    <= be_d;
      end
      if (state_q == Idle && trig_any && size_bad) begin
        sberror_valid_o <= 1'b1;
        sberror_o       <= 3'd4;
      end else if (state_q == Idle && trig_any && align_bad) begin
        sberror_valid_o <= 1'b1;
        sberror_o       <= 3'd3;
      end
      if (state_q != Idle && trig_any) sbbusyerror_o <= 1'b1;
      if (timeout) begin
        sberror_valid_o <= 1'b1;
        sberror_o       <= 3'd1;
      end
      if (rsp && master_r_err_i) begin
        sberror_valid_o <= 1'b1;
        sberror_o       <= 3'd2;
      end else if (rsp) begin
        if (!we_q) begin
          sbdata_o       <= rdata_aligned;
          sbdata_valid_o <= 1'b1;
        end
        if (sbautoincrement_i) begin
          sbaddress_o       <= addr_q + (AddrWidth'(1) << size_q);
          sbaddress_valid_o <= 1'b1;
        end
      end
    end
  end

  assign master_req_o   = (state_q == Req);
  assign master_we_o    = we_q;
  assign master_add_o   = {addr_q[AddrWidth-1:OffW], {OffW{1'b0}}};
  assign master_wdata_o = wdata_q;
  assign master_be_o    = be_q;
  assign sbbusy_o       = (state_q != Idle);

endmodule
